// File: rtl/data_mem_pkg.sv
// Shared definitions for the handshaked data memory and its load aligner.
//   - access size encodings carried on size_i
//   - FSM state encoding of the top-level controller
//   - size_bytes(): number of bytes touched by an access of a given size
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // The illegal size is always faulted before its byte count matters,
    // so it maps to 1 only to keep the gather/scatter loops well defined.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load result formatter (combinational).
// Takes the little-endian gathered bytes (byte 0 in bits [7:0]) and produces
// the 32-bit architectural load value, sign- or zero-extended by size.
// Ports:
//   raw_data  in  32  gathered bytes, unused upper lanes are don't-care
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD (SZ_BAD yields 0)
//   zext      in  1   1 = zero-extend, 0 = sign-extend
//   data      out 32  extended load result
module mem_load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] data
);

    logic sign_b;
    logic sign_h;

    assign sign_b = ~zext & raw_data[7];
    assign sign_h = ~zext & raw_data[15];

    always_comb begin
        data = '0;
        case (size)
            SZ_BYTE: data = {{24{sign_b}}, raw_data[7:0]};
            SZ_HALF: data = {{16{sign_h}}, raw_data[15:0]};
            SZ_WORD: data = raw_data;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed data memory for the MEM stage with a req/ready/ack handshake.
// An accepted request is latched, waits WAIT_CYCLES extra cycles in BUSY,
// commits (store bytes / load data / fault flag) on the BUSY->RESP edge and
// pulses ack_o for one cycle in RESP. Faulting accesses leave memory
// untouched and return rdata_o=0 with err_o=1.
// Ports:
//   clk_i       in   1       clock
//   rst_i       in   1       asynchronous active-high reset (memory array not cleared)
//   req_i       in   1       request, taken only while ready_o=1
//   we_i        in   1       1 = store, 0 = load
//   size_i      in   2       byte/half/word/illegal
//   unsigned_i  in   1       load extension select
//   addr_i      in   ADDR_W  byte address
//   wdata_i     in   32      store data, low bytes used
//   ready_o     out  1       high in IDLE
//   ack_o       out  1       one-cycle completion pulse
//   err_o       out  1       fault flag, only asserted together with ack_o
//   rdata_o     out  32      load result, held until the next commit
module data_memory_hs
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [31:0]       rdata_o
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ADDR_W:0]   wide_t;

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0]        mem [0:DEPTH_BYTES-1];

    logic              commit;
    logic [2:0]        nbytes;
    wide_t             last_addr;
    logic              misalign;
    logic              fault;
    idx_t              base;
    logic [31:0]       raw_data;
    logic [31:0]       load_data;

    // ---------------- fault check on the latched request ----------------
    assign nbytes = size_bytes(size_q);
    // One extra bit so an access near the top of the address space cannot
    // wrap back into range.
    assign last_addr = {1'b0, addr_q} + wide_t'(nbytes) - wide_t'(1);
    assign misalign  = ((size_q == SZ_HALF) && addr_q[0]) ||
                       ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    assign fault     = (size_q == SZ_BAD) || misalign ||
                       (last_addr >= wide_t'(DEPTH_BYTES));

    assign commit = (state == ST_BUSY) && (cnt == 4'd0);
    assign base   = addr_q[IDX_W-1:0];

    // ---------------- load gather + extension ----------------
    always_comb begin
        raw_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes)
                raw_data[8*k +: 8] = mem[base + idx_t'(k)];
        end
    end

    mem_load_align u_align (
        .raw_data (raw_data),
        .size     (size_q),
        .zext     (zext_q),
        .data     (load_data)
    );

    // ---------------- byte-lane store ----------------
    // No reset on the array: contents survive rst_i. A reset forces IDLE,
    // so an uncommitted store can never reach this block.
    always_ff @(posedge clk_i) begin
        if (commit && we_q && !fault) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes)
                    mem[base + idx_t'(k)] <= wdata_q[8*k +: 8];
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        size_q  <= size_i;
                        zext_q  <= unsigned_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt     <= 4'(WAIT_CYCLES);
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q <= (fault || we_q) ? 32'd0 : load_data;
                        err_q   <= fault;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_i)  next_state = ST_BUSY;
            ST_BUSY: if (commit) next_state = ST_RESP;
            ST_RESP:             next_state = ST_IDLE;
            default:             next_state = ST_IDLE;
        endcase
    end

    assign ready_o = (state == ST_IDLE);
    assign ack_o   = (state == ST_RESP);
    // err_q holds the last fault status; only expose it during the ack cycle.
    assign err_o   = ack_o & err_q;
    assign rdata_o = rdata_q;

endmodule
